// File: rtl/spi_pkg.sv
// Shared SPI definitions: arbiter FSM encoding and the frame width used by the
// master engine and everything that feeds it.
package spi_pkg;

  localparam int SPI_WORD_W = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LAUNCH  = 2'd1,
    WAIT    = 2'd2,
    RELEASE = 2'd3
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority encoder: returns the first set request bit at or above
// rr_ptr_i, wrapping modulo NUM_REQ.
module rr_pick #(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   rr_ptr_i,
  output logic [IDX_W-1:0]   winner_o,
  output logic               any_req_o
);

  logic [IDX_W:0] idx;

  // Walk from the farthest candidate back to rr_ptr so the nearest set bit wins.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch is inferred.
    winner_o  = '0;
    any_req_o = |req_i;
    idx       = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = {1'b0, rr_ptr_i} + (IDX_W + 1)'(k);
      if (idx >= (IDX_W + 1)'(NUM_REQ)) begin
        idx = idx - (IDX_W + 1)'(NUM_REQ);
      end
      if (req_i[idx[IDX_W-1:0]]) begin
        winner_o = idx[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/spi_rr_arbiter.sv
// Round-robin front end for a shared SPI master: grants one requester at a
// time, launches its word, waits for end-of-frame (or a watchdog) and releases.
module spi_rr_arbiter
  import spi_pkg::*;
#(
  parameter  int NUM_REQ     = 4,
  parameter  int WORD_W      = SPI_WORD_W,
  parameter  int TIMEOUT_CYC = 1024,
  localparam int IDX_W       = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*WORD_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        done,
  output logic                      err,
  output logic                      m_start,
  output logic [WORD_W-1:0]         m_data,
  output logic [IDX_W-1:0]          m_sel,
  input  logic                      m_busy,
  input  logic                      m_done
);

  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

  arb_state_t        state_q, state_d;
  logic [IDX_W-1:0]  cur_idx_q, cur_idx_d;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [WORD_W-1:0] m_data_q, m_data_d;
  logic [WD_W-1:0]   wd_cnt_q, wd_cnt_d;
  logic              err_flag_q, err_flag_d;
  logic [IDX_W-1:0]  winner;
  logic              any_req;
  logic [NUM_REQ-1:0] cur_onehot;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req_i    (req),
    .rr_ptr_i (rr_ptr_q),
    .winner_o (winner),
    .any_req_o(any_req)
  );

  always_comb begin
    state_d    = state_q;
    cur_idx_d  = cur_idx_q;
    rr_ptr_d   = rr_ptr_q;
    m_data_d   = m_data_q;
    wd_cnt_d   = wd_cnt_q;
    err_flag_d = err_flag_q;
    unique case (state_q)
      IDLE: begin
        if (!m_busy && any_req) begin
          state_d    = LAUNCH;
          cur_idx_d  = winner;
          m_data_d   = req_data[winner*WORD_W +: WORD_W];
          wd_cnt_d   = '0;
          err_flag_d = 1'b0;
        end
      end
      LAUNCH: begin
        state_d  = WAIT;
        wd_cnt_d = (wd_cnt_q == '1) ? wd_cnt_q : wd_cnt_q + 1'b1;
      end
      WAIT: begin
        // A done arriving on the watchdog's last cycle still counts as success.
        if (m_done) begin
          state_d    = RELEASE;
          err_flag_d = 1'b0;
        end else if (wd_cnt_q == WD_W'(TIMEOUT_CYC - 1)) begin
          state_d    = RELEASE;
          err_flag_d = 1'b1;
        end else begin
          wd_cnt_d = (wd_cnt_q == '1) ? wd_cnt_q : wd_cnt_q + 1'b1;
        end
      end
      RELEASE: begin
        state_d  = IDLE;
        rr_ptr_d = (cur_idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : cur_idx_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cur_idx_q  <= '0;
      rr_ptr_q   <= '0;
      m_data_q   <= '0;
      wd_cnt_q   <= '0;
      err_flag_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every flop update from pre-edge values.
      state_q    <= state_d;
      cur_idx_q  <= cur_idx_d;
      rr_ptr_q   <= rr_ptr_d;
      m_data_q   <= m_data_d;
      wd_cnt_q   <= wd_cnt_d;
      err_flag_q <= err_flag_d;
    end
  end

  // Outputs decode registered state only, so nothing is combinational from inputs.
  assign cur_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << cur_idx_q;
  assign gnt        = (state_q != IDLE)    ? cur_onehot : '0;
  assign done       = (state_q == RELEASE) ? cur_onehot : '0;
  assign err        = (state_q == RELEASE) && err_flag_q;
  assign m_start    = (state_q == LAUNCH);
  assign m_data     = m_data_q;
  assign m_sel      = cur_idx_q;

endmodule

// File: tb/tb_spi_rr_arbiter.sv
// Randomized scoreboard bench for spi_rr_arbiter: a transaction-level model
// predicts grant order, words, error flags and completion latency.
module tb_spi_rr_arbiter;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int TO = 16;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   gnt, done;
  logic           err, m_start;
  logic [W-1:0]   m_data;
  logic [1:0]     m_sel;
  logic           m_busy, m_done;

  typedef struct {
    int           idx;
    logic [W-1:0] data;
    bit           err;
    int           lat;
  } exp_t;

  exp_t         exp_q[$];
  exp_t         cur;
  int           dly_q[$];
  int           forced_dly[$];
  logic [W-1:0] mdl_words[N][$];
  logic [W-1:0] drv_words[N][$];
  int           mdl_ptr = 0;
  int           n_checks = 0;
  int           n_errors = 0;
  int           cyc = 0;
  bit           mon_en = 1'b0;
  bit           in_flight = 1'b0;
  int           t_start = 0;
  int           resp_cnt = 0;
  int           resp_d;

  spi_rr_arbiter #(.NUM_REQ(N), .WORD_W(W), .TIMEOUT_CYC(TO)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .req_data(req_data),
    .gnt     (gnt),
    .done    (done),
    .err     (err),
    .m_start (m_start),
    .m_data  (m_data),
    .m_sel   (m_sel),
    .m_busy  (m_busy),
    .m_done  (m_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // First pending requester at or after ptr, modulo N.
  function automatic int pick(input logic [N-1:0] p, input int ptr);
    for (int k = 0; k < N; k++) if (p[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  function automatic int next_dly(input int dmode);
    int r;
    if (forced_dly.size() > 0) return forced_dly.pop_front();
    if (dmode == 0) return $urandom_range(1, TO - 1);
    r = $urandom_range(0, 9);
    case (r)
      0:       return -1;
      1:       return TO - 1;
      2:       return TO;
      3:       return TO + 1;
      default: return $urandom_range(1, TO - 2);
    endcase
  endfunction

  // SPI master stand-in: pulses m_done d cycles after m_start (never if d < 1).
  always begin
    @(posedge clk);
    #1;
    m_done = 1'b0;
    if (resp_cnt > 0) begin
      resp_cnt--;
      if (resp_cnt == 0) m_done = 1'b1;
    end
    if (mon_en && m_start && dly_q.size() > 0) begin
      resp_d   = dly_q.pop_front();
      resp_cnt = (resp_d > 0) ? resp_d : 0;
    end
  end

  // Monitor: pops the scoreboard at each launch and checks the transfer to its done.
  always begin
    @(posedge clk);
    #1;
    if (mon_en) begin
      if (m_start) begin
        check("start_overlap", 32'(in_flight), 32'd0);
        if (exp_q.size() == 0) begin
          fail("unexpected_start");
        end else begin
          cur       = exp_q.pop_front();
          in_flight = 1'b1;
          t_start   = cyc;
          check("start_sel", 32'(m_sel), 32'(cur.idx));
          check("start_data", 32'(m_data), 32'(cur.data));
        end
      end
      if (in_flight) begin
        check("gnt_hold", 32'(gnt), 32'd1 << cur.idx);
        check("data_hold", 32'(m_data), 32'(cur.data));
        if (done != '0) begin
          check("done_vec", 32'(done), 32'd1 << cur.idx);
          check("done_err", 32'(err), 32'(cur.err));
          check("done_latency", 32'(cyc - t_start), 32'(cur.lat));
          in_flight = 1'b0;
        end else if (cyc - t_start > TO + 2) begin
          fail("done_missing");
          in_flight = 1'b0;
        end
      end else begin
        check("idle_outputs", {26'd0, err, done, gnt[0]}, 32'd0);
        check("idle_gnt", 32'(gnt), 32'd0);
      end
    end
  end

  task automatic run_phase(input logic [N-1:0] pat, input int max_rearm, input int dmode,
                           input bit drop, input int busy_cyc);
    logic [N-1:0] p;
    logic [W-1:0] wd;
    int total, got, first_idx, w, d, n;
    bit e;
    for (int i = 0; i < N; i++) begin
      if (pat[i] && mdl_words[i].size() == 0) begin
        n = 1 + $urandom_range(0, max_rearm);
        for (int k = 0; k < n; k++) begin
          wd = W'($urandom);
          mdl_words[i].push_back(wd);
          drv_words[i].push_back(wd);
        end
      end
    end
    p = pat; total = 0; first_idx = -1;
    while (p != '0) begin
      w = pick(p, mdl_ptr);
      if (first_idx < 0) first_idx = w;
      d  = next_dly(dmode);
      e  = (d < 1) || (d > TO - 1);
      wd = mdl_words[w].pop_front();
      exp_q.push_back('{idx: w, data: wd, err: e, lat: (e ? TO : d + 1)});
      dly_q.push_back(d);
      mdl_ptr = (w + 1) % N;
      if (mdl_words[w].size() == 0) p[w] = 1'b0;
      total++;
    end

    @(posedge clk);
    #1;
    if (busy_cyc > 0) m_busy = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (pat[i]) begin
        req_data[i*W +: W] = drv_words[i].pop_front();
        req[i] = 1'b1;
      end
    end
    for (int b = 0; b < busy_cyc; b++) begin
      @(posedge clk);
      #1;
      check("busy_blocks_gnt", 32'(gnt), 32'd0);
    end
    m_busy = 1'b0;

    got = 0;
    for (int c = 0; c < total * (TO + 24) + 20 && got < total; c++) begin
      @(posedge clk);
      #1;
      if (c == 0) check("grant_latency", 32'(gnt), 32'd1 << first_idx);
      if (drop && m_start && drv_words[m_sel].size() == 0) begin
        req[m_sel] = 1'b0;
        req_data[m_sel*W +: W] = W'($urandom);
      end
      for (int i = 0; i < N; i++) begin
        if (done[i]) begin
          got++;
          if (drv_words[i].size() > 0) req_data[i*W +: W] = drv_words[i].pop_front();
          else req[i] = 1'b0;
        end
      end
    end
    check("phase_done_count", 32'(got), 32'(total));
    repeat (3) @(posedge clk);
  endtask

  initial begin
    #500_000;
    $display("FAIL global_timeout (cycle %0d)", cyc);
    $fatal(1, "bench did not finish");
  end

  initial begin
    bit seen;
    logic [W-1:0] wd;
    req = '0; req_data = '0; m_busy = 1'b0; m_done = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_m_start", 32'(m_start), 32'd0);
    check("rst_m_sel", 32'(m_sel), 32'd0);
    check("rst_m_data", 32'(m_data), 32'd0);
    #2;
    rst_n = 1'b1;
    mon_en = 1'b1;

    // Single request from requester 1.
    mdl_words[1].push_back(16'h10FF);
    drv_words[1].push_back(16'h10FF);
    forced_dly.push_back(10);
    run_phase(4'b0010, 0, 0, 1'b0, 0);

    // All requesting, some re-arm at RELEASE.
    run_phase(4'b1111, 1, 0, 1'b0, 0);

    // Wrap and skip: pointer at 3, requesters 0 (two words) and 2.
    run_phase(4'b0100, 0, 0, 1'b0, 0);
    for (int k = 0; k < 2; k++) begin
      wd = W'($urandom);
      mdl_words[0].push_back(wd);
      drv_words[0].push_back(wd);
    end
    run_phase(4'b0101, 0, 0, 1'b0, 0);

    // Watchdog: hung, done on the timeout cycle, done during RELEASE, done during IDLE.
    forced_dly.push_back(-1);
    forced_dly.push_back(TO - 1);
    forced_dly.push_back(TO);
    forced_dly.push_back(TO + 1);
    run_phase(4'b1111, 0, 0, 1'b0, 0);
    run_phase(4'b0010, 0, 0, 1'b0, 0);

    // Stray m_done while idle must not produce a completion.
    @(posedge clk);
    #3;
    m_done = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #2;
      check("idle_mdone_done", {28'd0, done}, 32'd0);
      check("idle_mdone_err", 32'(err), 32'd0);
    end

    // Engine busy holds off the grant.
    run_phase(4'b0001, 0, 0, 1'b0, 4);

    for (int r = 0; r < 12; r++) begin
      run_phase(N'($urandom_range(1, 15)), $urandom_range(0, 2), 1,
                1'($urandom_range(0, 1)), 0);
    end

    // Reset in the middle of WAIT; pointer is left at 3 beforehand.
    run_phase(4'b0100, 0, 0, 1'b0, 0);
    @(posedge clk);
    #1;
    wd = W'($urandom);
    req[3] = 1'b1;
    req_data[3*W +: W] = wd;
    exp_q.push_back('{idx: 3, data: wd, err: 1'b1, lat: TO});
    dly_q.push_back(-1);
    seen = 1'b0;
    for (int c = 0; c < 5 && !seen; c++) begin
      @(posedge clk);
      #1;
      seen = m_start;
    end
    check("reset_test_launch", 32'(seen), 32'd1);
    repeat (3) @(posedge clk);
    #3;
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    check("midrst_gnt", 32'(gnt), 32'd0);
    check("midrst_m_start", 32'(m_start), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_err", 32'(err), 32'd0);
    check("midrst_m_sel", 32'(m_sel), 32'd0);
    check("midrst_m_data", 32'(m_data), 32'd0);
    req = '0;
    exp_q.delete();
    dly_q.delete();
    in_flight = 1'b0;
    resp_cnt  = 0;
    mdl_ptr   = 0;
    @(posedge clk);
    #3;
    rst_n  = 1'b1;
    mon_en = 1'b1;
    run_phase(4'b1010, 0, 0, 1'b0, 0);
    run_phase(4'b0100, 0, 0, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
